// File: rtl/hpdmc_dqcal.sv
// hpdmc_dqcal: DQ read-capture calibration controller.
// Resets the input delay line and walks every tap. At each tap it requests
// training reads and compares the captured words against the expected
// pattern. It keeps the widest passing window (the earliest one wins a tie),
// then re-seeds the delay line and steps it to the centre of that window.
// Optional build macro: HPDMC_DQCAL_TIMEOUT_EN adds a 12-bit watchdog in
// SAMPLE that aborts with fail=1 when no di_valid arrives for 4095 cycles.
module hpdmc_dqcal #(
   parameter int TAPS    = 300,
   parameter int TAP_W   = 9,
   parameter int SETTLE  = 8,
   parameter int SAMPLES = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [31:0]      pattern,
   input  logic [31:0]      di,
   input  logic             di_valid,
   output logic             rd_req,
   output logic             idelay_rst,
   output logic             idelay_ce,
   output logic             idelay_inc,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [TAP_W-1:0] tap_lo,
   output logic [TAP_W-1:0] tap_hi,
   output logic [TAP_W-1:0] tap_final
);

   // Window lengths run up to TAPS, which can equal 2^TAP_W.
   localparam int LEN_W = TAP_W + 1;
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int SMP_W = $clog2(SAMPLES + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRST,
      S_SETTLE,
      S_SAMPLE,
      S_EVAL,
      S_STEP,
      S_RESOLVE,
      S_CRST,
      S_CSTEP,
      S_CSETTLE
   } state_t;

   state_t             state, next_state;

   logic [TAP_W-1:0]   tap;
   logic [SET_W-1:0]   settle_cnt;
   logic [SMP_W-1:0]   sample_cnt;
   logic               err;

   logic               run_open;
   logic [TAP_W-1:0]   run_start;
   logic [LEN_W-1:0]   run_len;
   logic [TAP_W-1:0]   best_lo;
   logic [LEN_W-1:0]   best_len;

   logic [TAP_W-1:0]   step_cnt;
   logic               step_phase;   // 0: pulse slot, 1: gap slot

   logic               settle_done;
   logic               sample_last;
   logic               tap_last;
   logic               step_done;
   logic               timeout;

   // Candidate run after folding in the result of the current tap.
   logic               pass;
   logic               close_run;
   logic               cur_open;
   logic [TAP_W-1:0]   cur_start;
   logic [LEN_W-1:0]   cur_len;

   assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
   assign sample_last = di_valid && (sample_cnt == SMP_W'(SAMPLES - 1));
   assign tap_last    = (tap == TAP_W'(TAPS - 1));
   assign step_done   = (step_cnt == tap_final);

   assign pass      = !err;
   assign close_run = !pass || tap_last;
   assign cur_open  = run_open || pass;
   assign cur_start = run_open ? run_start : tap;
   // run_len stays below TAPS while a tap is still being evaluated,
   // so the increment cannot overflow.
   assign cur_len   = pass ? run_len + LEN_W'(1) : run_len;

`ifdef HPDMC_DQCAL_TIMEOUT_EN
   logic [11:0] wdog;

   assign timeout = (wdog == 12'hFFF);

   // Watchdog: counts SAMPLE cycles since the last valid word, saturating.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wdog <= '0;
      end else if (state != S_SAMPLE || di_valid) begin
         wdog <= '0;
      end else if (!timeout) begin
         wdog <= wdog + 12'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register.
   // NOTE: sequential state always uses non-blocking assignments, so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= S_IDLE;
      else            state <= next_state;
   end

   // Next-state logic and the delay/read command strobes.
   // NOTE: every output of this block gets a default before the case, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      next_state = state;
      rd_req     = 1'b0;
      idelay_rst = 1'b0;
      idelay_ce  = 1'b0;
      busy       = (state != S_IDLE);
      unique case (state)
         S_IDLE:    if (start) next_state = S_DRST;
         S_DRST: begin
            idelay_rst = 1'b1;
            next_state = S_SETTLE;
         end
         S_SETTLE:  if (settle_done) next_state = S_SAMPLE;
         S_SAMPLE: begin
            rd_req = !timeout;
            if (timeout)          next_state = S_IDLE;
            else if (sample_last) next_state = S_EVAL;
         end
         S_EVAL:    next_state = tap_last ? S_RESOLVE : S_STEP;
         S_STEP: begin
            idelay_ce  = 1'b1;
            next_state = S_SETTLE;
         end
         S_RESOLVE: next_state = (best_len == '0) ? S_IDLE : S_CRST;
         S_CRST: begin
            idelay_rst = 1'b1;
            next_state = S_CSTEP;
         end
         S_CSTEP: begin
            if (step_done)        next_state = S_CSETTLE;
            else if (!step_phase) idelay_ce  = 1'b1;
         end
         S_CSETTLE: if (settle_done) next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // The delay line only ever steps upward.
   assign idelay_inc = idelay_ce;

   // Sweep counters: settle timer, sample counter, error flag and tap index.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         settle_cnt <= '0;
         sample_cnt <= '0;
         err        <= 1'b0;
         tap        <= '0;
      end else begin
         if (state == S_SETTLE || state == S_CSETTLE) begin
            if (!settle_done) settle_cnt <= settle_cnt + SET_W'(1);
         end else begin
            settle_cnt <= '0;
         end

         if (state == S_SAMPLE) begin
            if (di_valid && !sample_last) sample_cnt <= sample_cnt + SMP_W'(1);
            if (di_valid && di != pattern) err <= 1'b1;
         end else begin
            sample_cnt <= '0;
         end

         // err must survive into EVAL, so it is cleared while settling.
         if (state == S_SETTLE) err <= 1'b0;

         if (state == S_DRST)                tap <= '0;
         else if (state == S_STEP && !tap_last) tap <= tap + TAP_W'(1);
      end
   end

   // Window tracking, result registers and the centring step sequencer.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_open   <= 1'b0;
         run_start  <= '0;
         run_len    <= '0;
         best_lo    <= '0;
         best_len   <= '0;
         done       <= 1'b0;
         fail       <= 1'b0;
         tap_lo     <= '0;
         tap_hi     <= '0;
         tap_final  <= '0;
         step_cnt   <= '0;
         step_phase <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  run_open  <= 1'b0;
                  run_start <= '0;
                  run_len   <= '0;
                  best_lo   <= '0;
                  best_len  <= '0;
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  tap_lo    <= '0;
                  tap_hi    <= '0;
                  tap_final <= '0;
               end
            end
            S_SAMPLE: begin
               if (timeout) fail <= 1'b1;
            end
            S_EVAL: begin
               if (close_run) begin
                  // Strictly greater keeps the earliest window on a tie.
                  if (cur_open && cur_len > best_len) begin
                     best_lo  <= cur_start;
                     best_len <= cur_len;
                  end
                  run_open <= 1'b0;
                  run_len  <= '0;
               end else begin
                  run_open  <= 1'b1;
                  run_start <= cur_start;
                  run_len   <= cur_len;
               end
            end
            S_RESOLVE: begin
               if (best_len == '0) begin
                  fail <= 1'b1;
               end else begin
                  tap_lo    <= best_lo;
                  tap_hi    <= best_lo + TAP_W'(best_len - LEN_W'(1));
                  tap_final <= best_lo + TAP_W'(best_len >> 1);
               end
            end
            S_CRST: begin
               step_cnt   <= '0;
               step_phase <= 1'b0;
            end
            S_CSTEP: begin
               if (!step_phase && !step_done) begin
                  step_cnt   <= step_cnt + TAP_W'(1);
                  step_phase <= 1'b1;
               end else begin
                  step_phase <= 1'b0;
               end
            end
            S_CSETTLE: begin
               if (settle_done) done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hpdmc_dqcal.sv
// Testbench for hpdmc_dqcal (TAPS=16). It models the delay line from the
// idelay commands and answers read requests with randomly timed words. Each
// tap passes or fails according to a mask. Expected windows come from a
// plain longest-run search over that mask. Spurious di_valid pulses are
// injected outside read requests.
module tb_hpdmc_dqcal;

   localparam int TAPS    = 16;
   localparam int TAP_W   = 4;
   localparam int SETTLE  = 8;
   localparam int SAMPLES = 16;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      pattern = 32'h0;
   logic [31:0]      di;
   logic             di_valid;
   logic             rd_req, idelay_rst, idelay_ce, idelay_inc;
   logic             busy, done, fail;
   logic [TAP_W-1:0] tap_lo, tap_hi, tap_final;

   hpdmc_dqcal #(.TAPS(TAPS), .TAP_W(TAP_W), .SETTLE(SETTLE), .SAMPLES(SAMPLES)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .pattern    (pattern),
      .di         (di),
      .di_valid   (di_valid),
      .rd_req     (rd_req),
      .idelay_rst (idelay_rst),
      .idelay_ce  (idelay_ce),
      .idelay_inc (idelay_inc),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .tap_lo     (tap_lo),
      .tap_hi     (tap_hi),
      .tap_final  (tap_final)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Delay-line model and command bookkeeping.
   int   tap_model = 0;
   int   max_tap = 0;
   int   gen = 0;
   int   rst_cnt = 0;
   int   sweep_steps = 0;
   int   centre_steps = 0;
   int   excl_viol = 0;
   int   dir_viol = 0;
   logic [15:0] pass_mask = 16'h0;
   bit   hold_valid = 1'b0;

   always @(posedge sys_clk) begin
      if (sys_rst_n) begin
         if (idelay_rst && idelay_ce) excl_viol <= excl_viol + 1;
         if (idelay_ce && !idelay_inc) dir_viol <= dir_viol + 1;
         if (idelay_rst) begin
            tap_model <= 0;
            rst_cnt   <= rst_cnt + 1;
            gen       <= gen + 1;
         end else if (idelay_ce) begin
            tap_model <= tap_model + 1;
            if (tap_model + 1 > max_tap) max_tap <= tap_model + 1;
            if (rst_cnt <= 1) sweep_steps <= sweep_steps + 1;
            else              centre_steps <= centre_steps + 1;
            gen <= gen + 1;
         end
      end
   end

   // Read responder: random valid timing; failing taps corrupt at least one word.
   initial begin
      int seen_gen;
      int word_idx;
      int bad_idx;
      bit bad;
      seen_gen = -1;
      word_idx = 0;
      bad_idx  = 0;
      di_valid = 1'b0;
      di       = 32'h0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (gen != seen_gen) begin
            seen_gen = gen;
            word_idx = 0;
            bad_idx  = $urandom_range(0, SAMPLES - 1);
         end
         if (rd_req && !hold_valid && $urandom_range(0, 2) != 0) begin
            bad = (tap_model < TAPS) && !pass_mask[tap_model[3:0]] &&
                  (word_idx == bad_idx || $urandom_range(0, 3) == 0);
            di_valid = 1'b1;
            di       = bad ? pattern ^ (32'h1 << $urandom_range(0, 31)) : pattern;
            word_idx++;
         end else begin
            di_valid = !hold_valid && !rd_req && ($urandom_range(0, 3) == 0);
            di       = $urandom;
         end
      end
   end

   // Reference: widest run of passing taps, earliest on a tie.
   task automatic model(input logic [15:0] m, output int lo, output int len);
      int s;
      int l;
      lo = 0; len = 0; s = 0; l = 0;
      for (int t = 0; t < TAPS; t++) begin
         if (m[t]) begin
            if (l == 0) s = t;
            l++;
            if (l > len) begin
               len = l;
               lo  = s;
            end
         end else begin
            l = 0;
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic clear_counts();
      @(negedge sys_clk);
      rst_cnt = 0; sweep_steps = 0; centre_steps = 0;
      excl_viol = 0; dir_viol = 0; max_tap = 0;
   endtask

   task automatic run_cal(input logic [15:0] m, input string name, input bit extra_start);
      int  lo, len, exp_final;
      bit  finished;
      bit  found;
      pass_mask = m;
      pattern   = $urandom;
      clear_counts();
      pulse_start();
      if (extra_start) begin
         repeat (100) @(negedge sys_clk);
         check({name, "_busy_mid"}, busy, 1'b1);
         start = 1'b1;
         @(negedge sys_clk);
         start = 1'b0;
      end
      finished = 1'b0;
      for (int c = 0; c < 20000 && !finished; c++) begin
         @(negedge sys_clk);
         if (done || fail) finished = 1'b1;
      end
      check({name, "_finished"}, finished, 1'b1);
      repeat (6) @(negedge sys_clk);
      model(m, lo, len);
      found     = (len != 0);
      exp_final = found ? lo + len / 2 : 0;
      check({name, "_done"}, done, found);
      check({name, "_fail"}, fail, !found);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_rd_req"}, rd_req, 1'b0);
      check({name, "_tap_lo"}, tap_lo, found ? lo : 0);
      check({name, "_tap_hi"}, tap_hi, found ? lo + len - 1 : 0);
      check({name, "_tap_final"}, tap_final, exp_final);
      check({name, "_rst_cnt"}, rst_cnt, found ? 2 : 1);
      check({name, "_sweep_steps"}, sweep_steps, TAPS - 1);
      check({name, "_centre_steps"}, centre_steps, exp_final);
      check({name, "_ce_rst_excl"}, excl_viol, 0);
      check({name, "_inc_dir"}, dir_viol, 0);
      check({name, "_max_tap"}, max_tap, TAPS - 1);
   endtask

   task automatic wait_rd_req(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge sys_clk);
         if (rd_req) seen = 1'b1;
      end
      check({name, "_rd_req_seen"}, seen, 1'b1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
      check({name, "_fail"}, fail, 1'b0);
      check({name, "_cmds"}, {rd_req, idelay_rst, idelay_ce, idelay_inc}, 4'h0);
      check({name, "_taps"}, {tap_lo, tap_hi, tap_final}, 12'h0);
   endtask

   initial begin
      #12;
      check_all_zero("reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_all_zero("idle");

      run_cal(16'h07E0, "win_5_10", 1'b0);
      run_cal(16'h0000, "all_fail", 1'b0);
      run_cal(16'h3E0C, "two_win", 1'b0);
      run_cal(16'h070E, "tie", 1'b0);
      run_cal(16'hF000, "top_edge", 1'b0);
      run_cal(16'hFFFF, "all_pass", 1'b0);
      run_cal(16'h0001, "single_0", 1'b0);
      for (int i = 0; i < 4; i++) run_cal(16'($urandom), $sformatf("rand%0d", i), 1'b0);

      // Asynchronous reset in the middle of SAMPLE.
      run_cal(16'h00F0, "pre_reset", 1'b0);
      pulse_start();
      wait_rd_req("mid_reset");
      repeat (2) @(negedge sys_clk);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      repeat (3) @(negedge sys_clk);
      check_all_zero("in_reset");
      sys_rst_n = 1'b1;

      // Fresh start with an ignored start pulse while busy.
      run_cal(16'h0FF0, "restart", 1'b1);

      // SAMPLE starvation.
      hold_valid = 1'b1;
      pass_mask  = 16'hFFFF;
      clear_counts();
      pulse_start();
      wait_rd_req("starve");
`ifdef HPDMC_DQCAL_TIMEOUT_EN
      begin
         bit seen_fail;
         seen_fail = 1'b0;
         for (int c = 0; c < 4300 && !seen_fail; c++) begin
            @(negedge sys_clk);
            if (fail) seen_fail = 1'b1;
         end
         check("starve_fail_seen", seen_fail, 1'b1);
         check("starve_rd_req", rd_req, 1'b0);
         check("starve_busy", busy, 1'b0);
         check("starve_done", done, 1'b0);
         repeat (5) @(negedge sys_clk);
         check("starve_no_centre", rst_cnt, 1);
      end
`else
      repeat (4300) @(negedge sys_clk);
      check("starve_fail", fail, 1'b0);
      check("starve_rd_req", rd_req, 1'b1);
      check("starve_busy", busy, 1'b1);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
`endif
      hold_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
